pipeif_fetch: RTL and testbench

Instruction-fetch stage that directly feeds the IF/ID instruction register. It holds the fetch PC and selects the next PC from pcsource: sequential, branch, jr, or jump. It runs a request/ready handshake with instruction memory and buffers fetched words in a 2-entry queue. It delivers (pc4, ins) to IF/ID, advances only when the hazard unit allows (wpc), and flushes wrong-path words on redirect.

---
 rtl/pipeif_fetch_pkg.sv | 34 +++
 rtl/pipeif_fetch_if_queue.sv | 60 ++++++
 rtl/pipeif_fetch.sv | 147 ++++++++++++++
 tb/tb_pipeif_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeif_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pipeif_fetch_pkg;

  // Next-PC source select driven by the control unit.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // Instruction presented to IF/ID when nothing has been fetched.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Number of fetched words buffered ahead of IF/ID.
  localparam logic [1:0] QUEUE_DEPTH = 2'd2;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One buffered fetch result: the sequential successor PC and the word.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ins;
  } fetch_entry_t;

  // Clear the byte-offset bits so the memory only ever sees word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeif_fetch_if_queue.sv
// Two-entry FIFO of fetch results with push, pop and synchronous flush.
module pipeif_fetch_if_queue
  import pipeif_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         clrn,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  // Pushes into a full queue and pops from an empty one are ignored.
  assign do_push = push_i && (count_q != QUEUE_DEPTH);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Storage: one register per slot, written when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic SLOT = 1'(gi);
    fetch_entry_t entry_q;

    // Capture the pushed word into this slot.
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        entry_q <= '0;
      end else if (do_push && !flush_i && (wr_ptr_q == SLOT)) begin
        entry_q <= push_data_i;
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count_o = count_q;
  assign head_o  = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: next-PC selection, memory handshake, and a
// two-word buffer feeding the IF/ID register, with wrong-path flushing.
module pipeif_fetch
  import pipeif_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;     // next address to fetch
  logic [31:0]  areg_q, areg_d;   // address of the transaction in flight
  logic         pend_q, pend_d;   // a request has been issued but not accepted

  logic         redirect;
  logic [31:0]  target;
  logic         req_c;
  logic         push_c;
  logic         pop_c;
  logic         flush_c;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_push_data;

  assign redirect = (pcsource != PCSRC_SEQ);

  // Redirect target chosen by pcsource; used exactly as supplied.
  always_comb begin
    target = bpc;
    unique case (pcsource)
      PCSRC_BR: target = bpc;
      PCSRC_JR: target = rpc;
      PCSRC_J:  target = jpc;
      default:  target = bpc;
    endcase
  end

  // Controller state, fetch PC and in-flight address registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      areg_q  <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      areg_q  <= areg_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic, request generation and queue control.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    areg_d  = areg_q;
    pend_d  = pend_q;
    req_c   = 1'b0;
    push_c  = 1'b0;
    flush_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) fpc_d = target;
      end

      ST_REQ: begin
        // Registered count keeps at most one transaction in flight; once
        // issued, the request is held until the memory accepts it.
        req_c = pend_q || (q_count < QUEUE_DEPTH);
        if (req_c && !pend_q) areg_d = fpc_q;

        if (redirect) begin
          fpc_d   = target;
          flush_c = 1'b1;
          if (req_c && !imem_ready) begin
            // The stale request cannot be withdrawn; let it drain first.
            state_d = ST_DROP;
            pend_d  = 1'b1;
          end else begin
            pend_d  = 1'b0;
          end
        end else if (req_c && imem_ready) begin
          push_c = 1'b1;
          fpc_d  = fpc_q + 32'd4;
          pend_d = 1'b0;
        end else if (req_c) begin
          pend_d = 1'b1;
        end
      end

      ST_DROP: begin
        // Finish the wrong-path transaction and throw its data away.
        req_c = 1'b1;
        if (redirect) fpc_d = target;
        if (imem_ready) begin
          state_d = ST_REQ;
          pend_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  // IF/ID consumes the head only when the hazard unit lets the PC advance.
  assign pop_c = wpc && if_valid && !redirect;

  assign q_push_data = '{pc4: fpc_q + 32'd4, ins: imem_rdata};

  pipeif_fetch_if_queue u_queue (
    .clk         (clk),
    .clrn        (clrn),
    .push_i      (push_c),
    .push_data_i (q_push_data),
    .pop_i       (pop_c),
    .flush_i     (flush_c),
    .count_o     (q_count),
    .head_o      (q_head)
  );

  assign imem_req  = req_c;
  assign imem_addr = word_align(pend_q ? areg_q : fpc_q);
  assign if_valid  = (q_count != 2'd0);
  assign ins       = if_valid ? q_head.ins : NOP_INST;
  assign pc4       = if_valid ? q_head.pc4 : 32'h0000_0000;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed bench for pipeif_fetch with a wait-state-programmable memory.
module tb_pipeif_fetch;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] jpc = 32'h0;
  logic        wpc = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc4;
  logic [31:0] ins;
  logic        if_valid;

  int tests = 0;
  int fails = 0;
  int waits = 0;
  int wcnt  = 0;

  pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .wpc        (wpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc4        (pc4),
    .ins        (ins),
    .if_valid   (if_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: a recognisable pattern derived from the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory slave: ready after `waits` extra cycles of a held request.
  assign imem_ready = imem_req && (wcnt == waits);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge clrn) begin
    if (!clrn || !imem_req) wcnt <= 0;
    else if (imem_ready)    wcnt <= 0;
    else                    wcnt <= wcnt + 1;
  end

  typedef struct {
    logic        wpc;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc4;
  } vec_t;

  vec_t vt[17];

  task automatic drive(input logic w, input logic [1:0] s, input logic [31:0] t);
    wpc      = w;
    pcsource = s;
    bpc      = (s == 2'b01) ? t : 32'h0BAD_0010;
    rpc      = (s == 2'b10) ? t : 32'h0BAD_0020;
    jpc      = (s == 2'b11) ? t : 32'h0BAD_0030;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the expected fetch-stage view.
  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc4);
    logic [31:0] src_addr;
    logic [31:0] e_ins;
    src_addr = e_pc4 - 32'd4;
    src_addr = {src_addr[31:2], 2'b00};
    e_ins    = e_valid ? mem_word(src_addr) : 32'h0;
    $display("[TB] %s: req=%0b addr=%h valid=%0b pc4=%h ins=%h", tag, imem_req, imem_addr,
             if_valid, pc4, ins);
    chk({tag, " req"}, {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) chk({tag, " addr"}, imem_addr, e_addr);
    chk({tag, " valid"}, {31'h0, if_valid}, {31'h0, e_valid});
    chk({tag, " pc4"}, pc4, e_pc4);
    chk({tag, " ins"}, ins, e_ins);
  endtask

  task automatic do_reset;
    clrn = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    // Zero-wait streaming, stall to full, branch when full, unaligned jr.
    vt[0]  = '{1'b1, 2'b00, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    vt[1]  = '{1'b1, 2'b00, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vt[2]  = '{1'b1, 2'b00, 32'h0,   1'b1, 32'h4,   1'b1, 32'h4};
    vt[3]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h8,   1'b1, 32'h8};
    vt[4]  = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vt[5]  = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vt[6]  = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vt[7]  = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vt[8]  = '{1'b1, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vt[9]  = '{1'b1, 2'b00, 32'h0,   1'b1, 32'hC,   1'b1, 32'hC};
    vt[10] = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h10,  1'b1, 32'h10};
    vt[11] = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10};
    vt[12] = '{1'b0, 2'b01, 32'h100, 1'b0, 32'h0,   1'b1, 32'h10};
    vt[13] = '{1'b1, 2'b00, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    vt[14] = '{1'b1, 2'b10, 32'h302, 1'b1, 32'h104, 1'b1, 32'h104};
    vt[15] = '{1'b1, 2'b00, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0};
    vt[16] = '{1'b1, 2'b00, 32'h0,   1'b1, 32'h304, 1'b1, 32'h306};

    waits = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].wpc, vt[i].src, vt[i].tgt);
      #1;
      chk_out($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].valid, vt[i].pc4);
      tick();
    end

    // Two wait states: request held three cycles, one word every three cycles.
    waits = 2;
    do_reset();
    drive(1'b1, 2'b00, 32'h0);
    #1 chk_out("w2 c0", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      #1 chk_out($sformatf("w2 c%0d", k), 1'b1, 32'h0, 1'b0, 32'h0);
      tick();
    end
    #1 chk_out("w2 c4", 1'b1, 32'h4, 1'b1, 32'h4);
    tick();
    for (int k = 5; k <= 6; k++) begin
      #1 chk_out($sformatf("w2 c%0d", k), 1'b1, 32'h4, 1'b0, 32'h0);
      tick();
    end
    #1 chk_out("w2 c7", 1'b1, 32'h8, 1'b1, 32'h8);
    tick();

    // Jump one cycle into a 3-wait transaction: stale word drained and dropped.
    waits = 3;
    do_reset();
    drive(1'b1, 2'b00, 32'h0);
    #1 chk_out("drop c0", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    #1 chk_out("drop c1", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 2'b11, 32'h200);
    #1 chk_out("drop c2", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 2'b00, 32'h0);
    #1 chk_out("drop c3", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    #1 chk_out("drop c4", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    for (int k = 5; k <= 8; k++) begin
      #1 chk_out($sformatf("drop c%0d", k), 1'b1, 32'h200, 1'b0, 32'h0);
      tick();
    end
    #1 chk_out("drop c9", 1'b1, 32'h204, 1'b1, 32'h204);
    tick();

    // Reset pulsed while a request is outstanding with one word buffered.
    waits = 3;
    do_reset();
    drive(1'b0, 2'b00, 32'h0);
    #1 chk_out("abort c0", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1 chk_out($sformatf("abort c%0d", k), 1'b1, 32'h0, 1'b0, 32'h0);
      tick();
    end
    #1 chk_out("abort c5", 1'b1, 32'h4, 1'b1, 32'h4);
    clrn = 1'b0;
    #1 chk_out("abort async", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    #1 chk_out("abort r0", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    #1 chk_out("abort r1", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
